// File: rtl/vscale_htif_pkg.sv
// Shared constants and FSM state type for the HTIF host-side controller.
package vscale_htif_pkg;

  localparam int unsigned HTIF_PCR_WIDTH     = 64;
  localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
  localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;
  localparam int unsigned HTIF_TOHOST_PASS   = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL_REQ  = 3'd1,
    ST_POLL_RESP = 3'd2,
    ST_CLR_REQ   = 3'd3,
    ST_CLR_RESP  = 3'd4,
    ST_WR_REQ    = 3'd5,
    ST_WR_RESP   = 3'd6,
    ST_DONE      = 3'd7
  } htif_state_e;

endpackage

// File: rtl/vscale_htif_interval_timer.sv
// Poll-interval down-counter: reloads to LOAD_VAL, decrements to zero and holds there.
module vscale_htif_interval_timer
  import vscale_htif_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= CNT_W'(LOAD_VAL);
    end else if (load) begin
      count <= CNT_W'(LOAD_VAL);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vscale_htif_host_ctrl.sv
// HTIF PCR host controller: polls tohost, clears it on exit, forwards fromhost writes.
// Optional watchdog (timeout port, MAX_CYCLES) enabled by VSCALE_HTIF_WATCHDOG_EN.
module vscale_htif_host_ctrl
  import vscale_htif_pkg::*;
#(
  parameter int unsigned PCR_WIDTH     = HTIF_PCR_WIDTH,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter logic [63:0] MAX_CYCLES    = 64'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 htif_pcr_req_valid,
  input  logic                 htif_pcr_req_ready,
  output logic                 htif_pcr_req_rw,
  output logic [11:0]          htif_pcr_req_addr,
  output logic [PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                 htif_pcr_resp_valid,
  output logic                 htif_pcr_resp_ready,
  input  logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
  input  logic                 host_wr_valid,
  output logic                 host_wr_ready,
  input  logic [PCR_WIDTH-1:0] host_wr_data,
  output logic                 done,
  output logic                 pass,
  output logic [PCR_WIDTH-2:0] exit_code,
  output logic [63:0]          cycle_count
`ifdef VSCALE_HTIF_WATCHDOG_EN
  ,
  output logic                 timeout
`endif
);

  htif_state_e state_q, state_d;
  logic tmr_load, tmr_dec, tmr_zero;
  logic wr_accept, term_latch, done_set, wd_hit;

  vscale_htif_interval_timer #(
    .LOAD_VAL(POLL_INTERVAL)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    wr_accept  = 1'b0;
    term_latch = 1'b0;
    done_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmr_dec = 1'b1;
        if (wd_hit) begin
          done_set = 1'b1;
          state_d  = ST_DONE;
        end else if (host_wr_valid) begin
          wr_accept = 1'b1;
          state_d   = ST_WR_REQ;
        end else if (tmr_zero) begin
          state_d = ST_POLL_REQ;
        end
      end
      ST_POLL_REQ: if (htif_pcr_req_ready) state_d = ST_POLL_RESP;
      ST_POLL_RESP: begin
        // A nonzero tohost always wins over a watchdog expiry in the same cycle.
        if (htif_pcr_resp_valid) begin
          if (htif_pcr_resp_data != '0) begin
            term_latch = 1'b1;
            state_d    = ST_CLR_REQ;
          end else if (wd_hit) begin
            done_set = 1'b1;
            state_d  = ST_DONE;
          end else begin
            tmr_load = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_CLR_REQ: if (htif_pcr_req_ready) state_d = ST_CLR_RESP;
      ST_CLR_RESP: begin
        if (htif_pcr_resp_valid) begin
          done_set = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_WR_REQ: if (htif_pcr_req_ready) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (htif_pcr_resp_valid) begin
          if (wd_hit) begin
            done_set = 1'b1;
            state_d  = ST_DONE;
          end else begin
            tmr_load = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request outputs are registered from the next state so they stay put while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      htif_pcr_req_valid <= 1'b0;
      htif_pcr_req_rw    <= 1'b0;
      htif_pcr_req_addr  <= '0;
      done               <= 1'b0;
      pass               <= 1'b0;
      exit_code          <= '0;
      cycle_count        <= '0;
    end else begin
      state_q            <= state_d;
      htif_pcr_req_valid <= (state_d == ST_POLL_REQ) || (state_d == ST_CLR_REQ) ||
                            (state_d == ST_WR_REQ);
      htif_pcr_req_rw    <= (state_d == ST_CLR_REQ) || (state_d == ST_WR_REQ);
      if (state_d == ST_WR_REQ) begin
        htif_pcr_req_addr <= CSR_ADDR_FROM_HOST;
      end else if ((state_d == ST_POLL_REQ) || (state_d == ST_CLR_REQ)) begin
        htif_pcr_req_addr <= CSR_ADDR_TO_HOST;
      end else begin
        htif_pcr_req_addr <= '0;
      end
      if (term_latch) begin
        exit_code <= htif_pcr_resp_data[PCR_WIDTH-1:1];
        pass      <= (htif_pcr_resp_data == PCR_WIDTH'(HTIF_TOHOST_PASS));
      end
      if (done_set) done <= 1'b1;
      if (!done && !(&cycle_count)) cycle_count <= cycle_count + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      htif_pcr_req_data <= host_wr_data;
    end else if (state_d != ST_WR_REQ) begin
      htif_pcr_req_data <= '0;
    end
  end

  // IDLE also sinks stray responses left over from an aborted transaction.
  assign htif_pcr_resp_ready = reset && ((state_q == ST_IDLE) || (state_q == ST_POLL_RESP) ||
                               (state_q == ST_CLR_RESP) || (state_q == ST_WR_RESP) ||
                               (state_q == ST_DONE));
  assign host_wr_ready = reset && wr_accept;

`ifdef VSCALE_HTIF_WATCHDOG_EN
  assign wd_hit = (MAX_CYCLES != 64'd0) && (cycle_count >= MAX_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else if (done_set && (state_q != ST_CLR_RESP)) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0 && (MAX_CYCLES != 64'd0);
`endif

endmodule

// File: doc/vscale_htif_host_ctrl.md
Name: vscale_htif_host_ctrl

Overview:
Host-side controller for the core's HTIF PCR port. It replaces hard-tied request signals with a sequenced poller.
- Periodically reads CSR tohost and acknowledges each nonzero value by clearing tohost to 0.
- Arbitrates host fromhost writes against polling.
- Reports test pass/fail and exit code to the simulation top or an FPGA wrapper.

Parameters:
PCR_WIDTH, 64, HTIF PCR data width (equals `HTIF_PCR_WIDTH).
POLL_INTERVAL, 16, idle cycles between tohost polls (≥1).
MAX_CYCLES, 0, watchdog limit in cycles; 0 disables it; used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
htif_pcr_req_valid  out  1  request valid
htif_pcr_req_ready  in  1  core accepts request
htif_pcr_req_rw  out  1  1=write, 0=read
htif_pcr_req_addr  out  12  CSR address (`CSR_ADDR_TO_HOST or `CSR_ADDR_FROM_HOST)
htif_pcr_req_data  out  PCR_WIDTH  write data
htif_pcr_resp_valid  in  1  response valid
htif_pcr_resp_ready  out  1  controller accepts response
htif_pcr_resp_data  in  PCR_WIDTH  response data
host_wr_valid  in  1  host requests fromhost write
host_wr_ready  out  1  host write accepted (1-cycle pulse)
host_wr_data  in  PCR_WIDTH  fromhost value
done  out  1  test finished (sticky)
pass  out  1  finished with tohost==1 (sticky)
exit_code  out  PCR_WIDTH-1  tohost>>1 of terminating value
cycle_count  out  64  cycles since reset release

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE; interval counter loads POLL_INTERVAL.
  - All outputs 0: req_valid, resp_ready, host_wr_ready, done, pass, exit_code, cycle_count.
  - Reset asserted mid-transaction aborts it. A response arriving after reset release, with no request outstanding, is accepted and discarded.
- States: IDLE, POLL_REQ, POLL_RESP, CLR_REQ, CLR_RESP, WR_REQ, WR_RESP, DONE.
- IDLE: interval counter decrements each cycle.
  - If host_wr_valid: pulse host_wr_ready, latch host_wr_data, go to WR_REQ. Host write has priority over the poll.
  - Else if counter==0: go to POLL_REQ.
- POLL_REQ: req_valid=1, rw=0, addr=TO_HOST. On req_ready go to POLL_RESP.
- POLL_RESP: resp_ready=1. On resp_valid:
  - data==0: reload counter, go to IDLE.
  - data!=0: latch exit_code=data>>1 and pass=(data==1), go to CLR_REQ.
- CLR_REQ: req_valid=1, rw=1, addr=TO_HOST, data=0. On req_ready go to CLR_RESP.
- CLR_RESP: on resp_valid set done=1, go to DONE.
- WR_REQ: req_valid=1, rw=1, addr=FROM_HOST, data=latched value. On req_ready go to WR_RESP.
- WR_RESP: on resp_valid reload counter, go to IDLE.
- DONE: terminal until reset. req_valid=0, resp_ready=1 (drains stray responses), host_wr_ready=0.
- Handshake rules:
  - req_* outputs are registered and held stable while valid && !ready.
  - Only one transaction outstanding at a time.
  - Request and response may complete in the same cycle the next request is issued: no bubble is required, but none is forbidden.
- cycle_count: increments every cycle after reset release; saturates at all-ones; frozen once done==1.

Optional Feature:
Macro VSCALE_HTIF_WATCHDOG_EN.
- Defined:
  - Adds output port timeout (1 bit, reset 0).
  - When MAX_CYCLES>0 and cycle_count reaches MAX_CYCLES, the FSM finishes any in-flight transaction, then enters DONE with done=1, pass=0, timeout=1, exit_code=0.
  - If tohost terminates in the same cycle the limit is reached, the tohost result wins and timeout=0.
- Undefined: no timeout port; MAX_CYCLES is ignored.

Decomposition:
- Shared package/include vscale_htif_pkg.vh holds:
  - FSM state encodings (3-bit localparams).
  - HTIF_TOHOST_PASS = 1.
  - Reuses `HTIF_PCR_WIDTH and the CSR address macros from existing headers.
- One sub-module: vscale_htif_interval_timer, which owns the poll down-counter (load, decrement, zero flag).

Test Plan:
- Core model returns tohost 0,0,1 on successive polls -> polls spaced POLL_INTERVAL+handshake cycles; write of 0 to TO_HOST issued; done=1, pass=1, exit_code=0.
- tohost=0x0B -> exit_code=5, pass=0, done=1; no further requests after DONE.
- Hold req_ready=0 for 7 cycles during POLL_REQ -> req_valid/addr/rw stable throughout; single transaction completes.
- host_wr_valid with data 0xDEAD asserted in the same cycle the poll is due -> host_wr_ready pulses; FROM_HOST write issued before the TO_HOST read.
- reset=0 asserted in POLL_RESP, then released -> all outputs 0, fresh poll after POLL_INTERVAL; late resp_valid discarded.
- With VSCALE_HTIF_WATCHDOG_EN, MAX_CYCLES=200, tohost always 0 -> timeout=1, done=1, pass=0 at cycle 200 (plus in-flight completion).
